// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch sequencer for the 8-bit CPU.
// Owns the program counter, reads instruction bytes from program memory over
// a request/acknowledge handshake and hands them to the IR with load/clear
// strobes. Every output is a flop (or the pc register itself), so no input
// reaches an output combinationally.
module fetch_unit #(
  parameter int ADDR_W   = 4,
  parameter int DATA_W   = 8,
  parameter int RESET_PC = 0,
  parameter int TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              clear_n,
  input  logic              start,
  input  logic              exec_done,
  input  logic              halt,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic [DATA_W-1:0] instr,
  output logic              ir_load,
  output logic              ir_clear,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              err
);

  // The counter only has to reach TIMEOUT-1: the final unacknowledged REQ
  // cycle is detected by comparison, not by counting past it.
  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [ADDR_W-1:0] PC_INIT  = ADDR_W'(RESET_PC);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    REQ    = 3'd1,
    LOAD   = 3'd2,
    EXEC   = 3'd3,
    HALTED = 3'd4
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wait_cnt;

  // The address bus is the program counter; it holds still for the whole REQ.
  assign mem_addr = pc;

  // Fetch sequencer: state, pc, captured byte, timeout counter and all strobes.
  always_ff @(posedge clk or negedge clear_n) begin
    if (!clear_n) begin
      state    <= IDLE;
      pc       <= PC_INIT;
      instr    <= '0;
      wait_cnt <= '0;
      mem_rd   <= 1'b0;
      ir_load  <= 1'b0;
      ir_clear <= 1'b0;
      busy     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted by a transition below.
      ir_load  <= 1'b0;
      ir_clear <= 1'b0;
      case (state)
        IDLE, HALTED: begin
          if (start) begin
            state    <= REQ;
            wait_cnt <= '0;
            mem_rd   <= 1'b1;
            busy     <= 1'b1;
            ir_clear <= 1'b1;
            err      <= 1'b0;
          end
        end
        REQ: begin
          // An acknowledge always beats the timeout, even on the last cycle.
          if (mem_ack) begin
            state   <= LOAD;
            instr   <= mem_data;
            mem_rd  <= 1'b0;
            ir_load <= 1'b1;
          end else if (wait_cnt == CNT_LAST) begin
            state  <= HALTED;
            mem_rd <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        LOAD: begin
          // pc wraps naturally at 2^ADDR_W.
          pc    <= pc + 1'b1;
          state <= EXEC;
        end
        EXEC: begin
          if (exec_done) begin
            if (halt) begin
              state <= HALTED;
              busy  <= 1'b0;
            end else begin
              if (jump_en) begin
                pc <= jump_addr;
              end
              state    <= REQ;
              wait_cnt <= '0;
              mem_rd   <= 1'b1;
            end
          end
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit. Stimulus pushes the expected
// (address, byte) of every fetch into a queue; a monitor pops and compares
// whenever the DUT raises ir_load. A behavioural memory answers mem_rd after
// a programmable number of wait states.
module tb_fetch_unit;

  logic       clk;
  logic       clear_n;
  logic       start;
  logic       exec_done;
  logic       halt;
  logic       jump_en;
  logic [3:0] jump_addr;
  logic       mem_ack;
  logic [7:0] mem_data;
  logic [3:0] mem_addr;
  logic       mem_rd;
  logic [7:0] instr;
  logic       ir_load;
  logic       ir_clear;
  logic [3:0] pc;
  logic       busy;
  logic       err;

  fetch_unit #(
    .ADDR_W  (4),
    .DATA_W  (8),
    .RESET_PC(0),
    .TIMEOUT (15)
  ) dut (
    .clk      (clk),
    .clear_n  (clear_n),
    .start    (start),
    .exec_done(exec_done),
    .halt     (halt),
    .jump_en  (jump_en),
    .jump_addr(jump_addr),
    .mem_ack  (mem_ack),
    .mem_data (mem_data),
    .mem_addr (mem_addr),
    .mem_rd   (mem_rd),
    .instr    (instr),
    .ir_load  (ir_load),
    .ir_clear (ir_clear),
    .pc       (pc),
    .busy     (busy),
    .err      (err)
  );

  typedef struct {
    logic [3:0] addr;
    logic [7:0] data;
  } exp_t;

  exp_t sbq[$];

  logic [7:0] mem [16];
  int  checks;
  int  errors;
  bit  ack_on;
  int  ack_delay;
  int  rq_cnt;
  int  run;
  int  last_run;
  int  load_cnt;
  int  clr_cnt;
  int  addr_moves;
  logic [3:0] run_addr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Memory model: ack after ack_delay wait states, data from the table.
  initial begin
    mem_ack  = 1'b0;
    mem_data = 8'h00;
    rq_cnt   = 0;
    forever begin
      @(negedge clk);
      if (mem_rd === 1'b1) begin
        mem_ack  = ack_on && (rq_cnt == ack_delay);
        mem_data = mem[mem_addr];
        rq_cnt++;
      end else begin
        mem_ack = 1'b0;
        rq_cnt  = 0;
      end
    end
  end

  // Monitor: scoreboard pop on ir_load, plus request-run and strobe counters.
  initial begin
    exp_t e;
    run = 0; last_run = 0; load_cnt = 0; clr_cnt = 0; addr_moves = 0;
    run_addr = '0;
    forever begin
      @(negedge clk);
      if (ir_load === 1'b1) begin
        load_cnt++;
        if (sbq.size() == 0) begin
          check("unexpected_ir_load", 32'(ir_load), 32'd0);
        end else begin
          e = sbq.pop_front();
          check("load_addr", 32'(mem_addr), 32'(e.addr));
          check("load_instr", 32'(instr), 32'(e.data));
        end
      end
      if (ir_clear === 1'b1) clr_cnt++;
      if (mem_rd === 1'b1) begin
        if (run == 0) run_addr = mem_addr;
        else if (mem_addr !== run_addr) addr_moves++;
        run++;
      end else begin
        if (run != 0) last_run = run;
        run = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [3:0] a, input logic [7:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    sbq.push_back(e);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic pulse_exec(input logic h, input logic j, input logic [3:0] a);
    exec_done = 1'b1;
    halt      = h;
    jump_en   = j;
    jump_addr = a;
    @(negedge clk);
    exec_done = 1'b0;
    halt      = 1'b0;
    jump_en   = 1'b0;
    jump_addr = 4'h0;
  endtask

  task automatic wait_load(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ir_load !== 1'b1 && n < budget);
    if (ir_load !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_load: got no ir_load within %0d cycles expected one", budget);
    end
  endtask

  initial begin
    mem = '{8'hA5, 8'h3C, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66,
            8'h77, 8'h88, 8'h99, 8'hAA, 8'hC7, 8'hDD, 8'hEE, 8'hF1};
    checks = 0; errors = 0;
    clear_n = 1'b0; start = 1'b0; exec_done = 1'b0; halt = 1'b0;
    jump_en = 1'b0; jump_addr = 4'h0;
    ack_on = 1'b1; ack_delay = 0;

    repeat (2) @(negedge clk);
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    check("rst_err", 32'(err), 32'h0);
    check("rst_mem_rd", 32'(mem_rd), 32'h0);
    check("rst_ir_load", 32'(ir_load), 32'h0);
    check("rst_instr", 32'(instr), 32'h0);
    clear_n = 1'b1;
    @(negedge clk);

    // Zero-wait fetch from address 0
    push(4'h0, 8'hA5);
    pulse_start();
    check("zw_ir_clear", 32'(ir_clear), 32'h1);
    check("zw_mem_rd", 32'(mem_rd), 32'h1);
    check("zw_mem_addr", 32'(mem_addr), 32'h0);
    check("zw_busy", 32'(busy), 32'h1);
    wait_load(5);
    @(negedge clk);
    check("zw_pc", 32'(pc), 32'h1);
    check("zw_rd_cycles", 32'(last_run), 32'd1);
    check("zw_loads", 32'(load_cnt), 32'd1);
    check("zw_clears", 32'(clr_cnt), 32'd1);

    // Three wait states at address 1
    ack_delay = 3;
    push(4'h1, 8'h3C);
    pulse_exec(1'b0, 1'b0, 4'h0);
    check("ws_mem_addr", 32'(mem_addr), 32'h1);
    wait_load(10);
    @(negedge clk);
    check("ws_pc", 32'(pc), 32'h2);
    check("ws_rd_cycles", 32'(last_run), 32'd4);
    check("ws_loads", 32'(load_cnt), 32'd2);

    // Jump to 0xC
    ack_delay = 0;
    push(4'hC, 8'hC7);
    pulse_exec(1'b0, 1'b1, 4'hC);
    check("jmp_mem_addr", 32'(mem_addr), 32'hC);
    wait_load(5);
    @(negedge clk);
    check("jmp_pc", 32'(pc), 32'hD);

    // Halt wins over jump
    pulse_exec(1'b1, 1'b1, 4'h5);
    check("halt_pc", 32'(pc), 32'hD);
    check("halt_busy", 32'(busy), 32'h0);
    repeat (4) @(negedge clk);
    check("halt_mem_rd", 32'(mem_rd), 32'h0);
    check("halt_pc_held", 32'(pc), 32'hD);
    check("halt_loads", 32'(load_cnt), 32'd3);

    // Resume at 0xD, then run through the wrap at 0xF
    push(4'hD, 8'hDD);
    pulse_start();
    check("res_mem_addr", 32'(mem_addr), 32'hD);
    wait_load(5);
    @(negedge clk);
    check("res_pc", 32'(pc), 32'hE);
    push(4'hE, 8'hEE);
    pulse_exec(1'b0, 1'b0, 4'h0);
    wait_load(5);
    @(negedge clk);
    push(4'hF, 8'hF1);
    pulse_exec(1'b0, 1'b0, 4'h0);
    check("wrap_mem_addr_f", 32'(mem_addr), 32'hF);
    wait_load(5);
    @(negedge clk);
    check("wrap_pc", 32'(pc), 32'h0);
    push(4'h0, 8'hA5);
    pulse_exec(1'b0, 1'b0, 4'h0);
    check("wrap_mem_addr_0", 32'(mem_addr), 32'h0);
    wait_load(5);
    @(negedge clk);
    check("wrap_pc_next", 32'(pc), 32'h1);

    // Timeout: no acknowledge at address 1
    ack_on = 1'b0;
    pulse_exec(1'b0, 1'b0, 4'h0);
    for (int i = 0; i < 40 && mem_rd === 1'b1; i++) @(negedge clk);
    @(negedge clk);
    check("to_rd_cycles", 32'(last_run), 32'd15);
    check("to_err", 32'(err), 32'h1);
    check("to_busy", 32'(busy), 32'h0);
    check("to_pc", 32'(pc), 32'h1);
    check("to_instr", 32'(instr), 32'hA5);

    // Restart; acknowledge arrives in the 15th cycle
    ack_on = 1'b1;
    ack_delay = 14;
    push(4'h1, 8'h3C);
    pulse_start();
    check("rt_err_cleared", 32'(err), 32'h0);
    check("rt_ir_clear", 32'(ir_clear), 32'h1);
    check("rt_mem_addr", 32'(mem_addr), 32'h1);
    wait_load(30);
    @(negedge clk);
    check("rt_rd_cycles", 32'(last_run), 32'd15);
    check("rt_err", 32'(err), 32'h0);
    check("rt_pc", 32'(pc), 32'h2);

    // Asynchronous reset in the middle of a request
    ack_on = 1'b0;
    pulse_exec(1'b0, 1'b0, 4'h0);
    @(posedge clk);
    #2;
    check("ar_pre_mem_rd", 32'(mem_rd), 32'h1);
    clear_n = 1'b0;
    #1;
    check("ar_mem_rd", 32'(mem_rd), 32'h0);
    check("ar_pc", 32'(pc), 32'h0);
    check("ar_busy", 32'(busy), 32'h0);
    check("ar_err", 32'(err), 32'h0);
    check("ar_ir_load", 32'(ir_load), 32'h0);
    @(negedge clk);
    check("sb_empty", 32'(sbq.size()), 32'd0);
    check("addr_stable", 32'(addr_moves), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch sequencer for the 8-bit CPU. It is the producer side of the instruction register: it owns the program counter, reads instruction bytes from program memory through a request/acknowledge handshake, and drives the byte plus load/clear strobes into the IR.
- It waits for the execute/decode logic to report completion, then fetches the next, jumped-to, or no further instruction.

Parameters:
- ADDR_W, 4, program counter / memory address width (matches the 4-bit operand field).
- DATA_W, 8, instruction width.
- RESET_PC, 0, PC value after reset.
- TIMEOUT, 15, maximum REQ cycles allowed without mem_ack before the fetch aborts (must be ≥1).

Ports:
- clk  in  1  system clock, rising edge.
- clear_n  in  1  asynchronous active-low reset.
- start  in  1  begin/resume fetching; honoured only in IDLE or HALTED.
- exec_done  in  1  current instruction has finished executing.
- halt  in  1  with exec_done: stop after this instruction.
- jump_en  in  1  with exec_done: load PC from jump_addr.
- jump_addr  in  ADDR_W  branch target.
- mem_ack  in  1  memory data valid this cycle.
- mem_data  in  DATA_W  instruction byte from memory.
- mem_addr  out  ADDR_W  fetch address; equals pc.
- mem_rd  out  1  read request.
- instr  out  DATA_W  captured instruction byte, to IR data input.
- ir_load  out  1  IR load strobe.
- ir_clear  out  1  IR clear strobe.
- pc  out  ADDR_W  program counter.
- busy  out  1  high in REQ, LOAD, EXEC.
- err  out  1  sticky fetch-timeout flag.

Behaviour:
- Reset (clear_n low, asynchronous, effective mid-operation):
  - state = IDLE, pc = RESET_PC, instr = 0, timeout counter = 0.
  - mem_rd, ir_load, ir_clear, busy and err all go to 0 immediately.
- All outputs are registered or decoded from registered state only; no combinational path from any input to any output.
- IDLE: start = 1 → next state REQ, ir_clear = 1 for that single transition cycle (registered, visible during the first REQ cycle), err cleared.
- REQ:
  - mem_rd = 1 every cycle; mem_addr = pc, held stable.
  - If mem_ack = 1 at an edge: instr ← mem_data, next state LOAD. An acknowledge in the first REQ cycle is legal, giving zero wait states.
  - Counter counts REQ cycles without acknowledge. If the TIMEOUT-th REQ cycle has no ack: next state HALTED, err ← 1, pc unchanged, instr unchanged.
  - mem_rd is therefore high for exactly TIMEOUT cycles on abort. An ack in the final cycle wins over the timeout.
- LOAD:
  - ir_load = 1 for exactly one cycle; instr stable; mem_rd = 0.
  - At the edge ending LOAD: pc ← pc + 1 modulo 2^ADDR_W (0xF wraps to 0x0); next state EXEC.
- EXEC: wait for exec_done = 1. Priority when it arrives:
  - halt → HALTED, pc unchanged.
  - else jump_en → pc ← jump_addr, then REQ.
  - else → REQ with the incremented pc.
  - jump_en, halt and jump_addr are ignored unless sampled together with exec_done in EXEC.
- HALTED:
  - busy = 0, mem_rd = 0, pc and instr held.
  - start → REQ with one-cycle ir_clear; err cleared; resumes at current pc.
- start is ignored in REQ, LOAD and EXEC. mem_ack is ignored outside REQ. exec_done is ignored outside EXEC.
- Timing:
  - Minimum fetch is 2 cycles: REQ with immediate ack, then LOAD.
  - The IR captures instr on the rising edge at the end of the LOAD cycle.
- Timeout counter resets on every entry to REQ.

Test Plan:
- Reset: hold clear_n = 0 mid-REQ with mem_rd = 1 → mem_rd drops without waiting for clk; pc = 0, busy = 0, err = 0, ir_load = 0.
- Zero-wait fetch: mem[0] = 0xA5, ack same cycle as mem_rd, start pulse → one ir_clear pulse, mem_addr = 0, single ir_load cycle with instr = 0xA5, pc = 1. exec_done → next mem_addr = 1.
- Wait states: ack delayed 3 cycles → mem_rd high 4 cycles, mem_addr constant, exactly one ir_load, pc increments by 1.
- Control flow:
  - exec_done + jump_en, jump_addr = 0xC → next mem_addr = 0xC.
  - Later exec_done + halt + jump_en → HALTED, pc unchanged, mem_rd stays 0.
  - start → fetch resumes at that pc.
- Wrap: fetch at pc = 0xF → pc = 0x0 after LOAD, next fetch at address 0.
- Timeout: no ack with TIMEOUT = 15 → mem_rd high exactly 15 cycles, err = 1, HALTED, pc unchanged. start clears err and refetches the same address. Repeat with ack in cycle 15 → normal LOAD, err = 0.
